// File: rtl/lcd_pixel_sink.sv
// lcd_pixel_sink: palette-maps PPU pixels, tracks screen x/y and streams them to the framebuffer through a FIFO
module lcd_pixel_sink #(
    parameter int H_PIXELS   = 160,
    parameter int V_LINES    = 144,
    parameter int FIFO_DEPTH = 16,
    parameter int FB_ADDR_W  = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           PX_IN,
    input  logic                 PX_valid,
    input  logic [1:0]           PPU_MODE,
    input  logic                 LCD_EN,
    input  logic [7:0]           BGP,
    output logic                 FB_WR,
    output logic [FB_ADDR_W-1:0] FB_ADDR,
    output logic [1:0]           FB_DATA,
    input  logic                 FB_READY,
    output logic                 FRAME_DONE,
    output logic                 OVERFLOW,
    output logic                 LINE_ERR,
    input  logic                 ERR_CLR
);
    localparam int XW = $clog2(H_PIXELS + 1);
    localparam int YW = $clog2(V_LINES + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = FB_ADDR_W + 2;
    localparam logic [XW-1:0] H_MAX = XW'(H_PIXELS);
    localparam logic [YW-1:0] V_MAX = YW'(V_LINES);
    localparam logic [FB_ADDR_W-1:0] LINE_STEP = FB_ADDR_W'(H_PIXELS);
    localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);
    localparam logic [1:0] S_IDLE = 2'd0, S_ACTIVE = 2'd1, S_DRAIN = 2'd2;
    localparam logic [1:0] M_HBLANK = 2'd0, M_VBLANK = 2'd1, M_DRAW = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [1:0]           mode_q;
    logic [XW-1:0]        x_q, x_d, x_adv;
    logic [YW-1:0]        y_q, y_d;
    logic [FB_ADDR_W-1:0] base_q, base_d;
    logic [PW-1:0]        wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [EW-1:0]        mem [FIFO_DEPTH];
    logic [EW-1:0]        out_q, out_d, entry, head;
    logic                 out_valid_q, out_valid_d;
    logic                 frame_done_q, ovf_q, ovf_d, lerr_q, lerr_d;
    logic                 line_end, frame_end, want, in_range, attempt, pos_clr, y_step;
    logic                 out_free, fifo_empty, fifo_full, pop, push, bypass, fifo_wr;
    logic                 drop_full, line_err_ev, drain_done;
    logic [1:0]           shade;

    assign FB_WR      = out_valid_q;
    assign FB_ADDR    = out_q[EW-1:2];
    assign FB_DATA    = out_q[1:0];
    assign FRAME_DONE = frame_done_q;
    assign OVERFLOW   = ovf_q;
    assign LINE_ERR   = lerr_q;

    // Push/pop arbitration, position tracking and control next-state
    always_comb begin
        line_end    = mode_q == M_DRAW && PPU_MODE == M_HBLANK;
        frame_end   = PPU_MODE == M_VBLANK && mode_q != M_VBLANK;
        want        = PX_valid && LCD_EN;
        in_range    = x_q < H_MAX && y_q < V_MAX;
        attempt     = want && in_range;
        shade       = BGP[{PX_IN, 1'b0} +: 2];
        entry       = {base_q + FB_ADDR_W'(x_q), shade};
        head        = mem[rd_q];
        out_free    = !out_valid_q || FB_READY;
        fifo_empty  = cnt_q == '0;
        fifo_full   = cnt_q == DEPTH;
        pop         = out_free && !fifo_empty;
        push        = attempt && (!fifo_full || pop);
        bypass      = push && out_free && fifo_empty;
        fifo_wr     = push && !bypass;
        drop_full   = attempt && !push;
        x_adv       = attempt ? x_q + XW'(1) : x_q;
        line_err_ev = (want && !in_range) || (line_end && LCD_EN && x_adv != H_MAX);
        pos_clr     = !LCD_EN || frame_end;
        y_step      = line_end && y_q < V_MAX;
        x_d         = (pos_clr || line_end) ? '0 : x_adv;
        y_d         = pos_clr ? '0 : y_step ? y_q + YW'(1) : y_q;
        base_d      = pos_clr ? '0 : y_step ? base_q + LINE_STEP : base_q;
        wr_d        = fifo_wr ? wr_q + PW'(1) : wr_q;
        rd_d        = pop ? rd_q + PW'(1) : rd_q;
        cnt_d       = (fifo_wr && !pop) ? cnt_q + CW'(1) : (!fifo_wr && pop) ? cnt_q - CW'(1) : cnt_q;
        out_valid_d = pop || bypass || (out_valid_q && !FB_READY);
        out_d       = pop ? head : bypass ? entry : out_q;
        drain_done  = state_q == S_DRAIN && LCD_EN && fifo_empty && !out_valid_q;
        state_d     = !LCD_EN ? S_IDLE :
                      state_q == S_IDLE ? S_ACTIVE :
                      (state_q == S_ACTIVE && frame_end) ? S_DRAIN :
                      drain_done ? S_ACTIVE : state_q;
        ovf_d       = drop_full || (ovf_q && !ERR_CLR);
        lerr_d      = line_err_ev || (lerr_q && !ERR_CLR);
    end

    // Control, position, FIFO pointer and output register state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            mode_q       <= M_HBLANK;
            x_q          <= '0;
            y_q          <= '0;
            base_q       <= '0;
            wr_q         <= '0;
            rd_q         <= '0;
            cnt_q        <= '0;
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            ovf_q        <= 1'b0;
            lerr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= PPU_MODE;
            x_q          <= x_d;
            y_q          <= y_d;
            base_q       <= base_d;
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            cnt_q        <= cnt_d;
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= drain_done;
            ovf_q        <= ovf_d;
            lerr_q       <= lerr_d;
        end
    end

    // Pixel FIFO storage; contents are qualified by the pointers so no reset is needed
    always_ff @(posedge clk) begin
        if (fifo_wr) mem[wr_q] <= entry;
    end
endmodule

// File: doc/lcd_pixel_sink.md
Name: lcd_pixel_sink

Overview:
- Consumer end of the PPU pixel output (2-bit pixel + valid strobe, plus PPU mode).
- Maps each pixel through the BGP palette and tracks screen x/y from PPU mode transitions.
- Buffers pixels in a small FIFO, then writes them to a 160x144 framebuffer over a valid/ready write port.
- Sits between the PPU and the display/framebuffer logic; absorbs framebuffer backpressure and flags protocol errors.

Parameters:
- H_PIXELS, 160, pixels per line.
- V_LINES, 144, visible lines per frame.
- FIFO_DEPTH, 16, pixel FIFO entries (power of two).
- FB_ADDR_W, 15, framebuffer address width (160*144 = 23040 < 2^15).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- PX_IN  in  2  raw pixel colour index from PPU
- PX_valid  in  1  PX_IN valid this cycle
- PPU_MODE  in  2  PPU mode: 0 H_BLANK, 1 V_BLANK, 2 SCAN, 3 DRAW
- LCD_EN  in  1  LCDC[7]
- BGP  in  8  background palette register
- FB_WR  out  1  framebuffer write valid
- FB_ADDR  out  FB_ADDR_W  framebuffer address, y*160+x
- FB_DATA  out  2  palette-mapped shade
- FB_READY  in  1  framebuffer accepts write
- FRAME_DONE  out  1  one-cycle pulse: frame fully written
- OVERFLOW  out  1  sticky: pixel dropped on full FIFO
- LINE_ERR  out  1  sticky: line pixel count not equal to H_PIXELS
- ERR_CLR  in  1  clears OVERFLOW and LINE_ERR

Behaviour:
- Reset (rst=0, async):
  - FB_WR, FB_ADDR, FB_DATA, FRAME_DONE, OVERFLOW and LINE_ERR are all 0.
  - FIFO is empty; x=0, y=0, line_base=0; state is IDLE.
- Push side:
  - A pixel is accepted when PX_valid=1, LCD_EN=1 and x<H_PIXELS.
  - Shade = BGP[2*PX_IN+1 : 2*PX_IN], sampled in the accept cycle.
  - Entry pushed = {line_base+x, shade}; then x increments.
  - line_base is maintained incrementally (+160 per line); no multiplier.
- x>=H_PIXELS with PX_valid=1: pixel is dropped and LINE_ERR is set.
- FIFO full:
  - A push is allowed if a pop occurs in the same cycle.
  - Otherwise the pixel is dropped, OVERFLOW is set, and x still increments so later addresses stay aligned.
- Pop side:
  - FB_WR=1 whenever the output register holds an entry.
  - Transfer completes when FB_WR && FB_READY.
  - FB_ADDR and FB_DATA are held stable while FB_WR=1 && !FB_READY.
  - Output register refills from the FIFO in the same cycle as a transfer, giving back-to-back writes at 1/cycle.
- Latency: pixel accepted at cycle N -> FB_WR=1 at cycle N+1 (empty FIFO, FB_READY=1).
- Line end (PPU_MODE 3 -> 0, detected against registered previous mode):
  - If x != H_PIXELS, LINE_ERR is set.
  - x resets to 0; y and line_base advance.
  - A pixel accepted in the same cycle as the transition belongs to the old line.
- Frame end (PPU_MODE enters 1 from any other mode): x=0, y=0, line_base=0; state goes to DRAIN.
- State machine:
  - IDLE: LCD_EN=0. Go to ACTIVE on LCD_EN=1.
  - ACTIVE: accept pixels. Go to DRAIN on V_BLANK entry. Go to IDLE on LCD_EN=0.
  - DRAIN: keep writing. When the FIFO and output register are both empty, pulse FRAME_DONE for 1 cycle and go to ACTIVE. Pixels arriving in DRAIN are accepted as the next frame.
- LCD_EN falls mid-operation:
  - x, y and line_base reset; pushes stop.
  - Buffered entries still drain. FB_WR is never withdrawn before acceptance.
  - No FRAME_DONE pulse.
- ERR_CLR=1 clears both sticky flags. If an error event occurs in the same cycle, the event wins (flag stays 1).
- y beyond V_LINES-1 (no V_BLANK seen): addresses are not produced for those lines; pixels are dropped and LINE_ERR is set.

Test Plan:
- BGP=0xE4, FB_READY=1; 160 valid pixels PX_IN=x[1:0] on line 0, then mode 3->0 -> 160 writes: addr 0..159, data=x[1:0], first FB_WR one cycle after the first valid; LINE_ERR=0.
- BGP=0x1B (inverted), line 1, PX_IN=3 -> FB_ADDR=160, FB_DATA=0.
- FB_READY=0 for 40 cycles during a 160-pixel burst:
  - OVERFLOW=1 after entry 17 (16 in FIFO plus 1 in output register).
  - Once FB_READY returns, addresses resume at the correct x with no gap in line_base.
  - FB_ADDR/FB_DATA remain stable while stalled.
- 144 full lines, then mode->1 with FB_READY toggling 50% -> exactly one FRAME_DONE pulse, after the last write (addr 23039) completes; the next frame starts at addr 0.
- Line with 150 pixels then mode 3->0 -> LINE_ERR=1; the next line starts at addr 160*(y+1). ERR_CLR pulse -> LINE_ERR=0.
- Reset asserted while FB_WR=1 and the FIFO is half full -> all outputs 0 immediately (asynchronous), FIFO empty, state IDLE.
